// File: rtl/regfile_writeback_queue.sv
// Writeback queue driving the RegisterFile write port, with forwarding of pending values.
// Optional feature: define REGWB_COALESCE_EN to merge back-to-back writes to the same register.
module regfile_writeback_queue #(
  parameter int DEPTH   = 4,
  parameter bit DROP_R0 = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_reg,
  input  logic [31:0] in_data,
  input  logic        wb_hold,
  output logic        RegWrite,
  output logic [4:0]  wr_reg,
  output logic [31:0] wr_data,
  input  logic [4:0]  rd_reg1,
  input  logic [4:0]  rd_reg2,
  output logic        fwd_hit1,
  output logic [31:0] fwd_data1,
  output logic        fwd_hit2,
  output logic [31:0] fwd_data2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]    q_reg  [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic push;
  logic pop;
  logic alloc;
  logic coalesce;

  assign pop  = (count != '0) && !wb_hold;
  assign push = in_valid && in_ready && !(DROP_R0 && (in_reg == 5'd0));

`ifdef REGWB_COALESCE_EN
  logic [PW-1:0] last;
  logic          tail_match;

  assign last       = tail - PW'(1);
  assign tail_match = (count != '0) && (q_reg[last] == in_reg);
  assign in_ready   = (count != CW'(DEPTH)) | tail_match;
  // The youngest entry may be leaving this cycle; then allocate normally.
  assign coalesce   = push && tail_match && !(pop && (count == CW'(1)));
`else
  assign in_ready   = (count != CW'(DEPTH));
  assign coalesce   = 1'b0;
`endif

  assign alloc = push && !coalesce;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      RegWrite <= 1'b0;
      wr_reg   <= '0;
      wr_data  <= '0;
    end else begin
      if (pop) begin
        RegWrite <= 1'b1;
        wr_reg   <= q_reg[head];
        wr_data  <= q_data[head];
        head     <= head + PW'(1);
      end else begin
        RegWrite <= 1'b0;
      end
      if (alloc) begin
        tail <= tail + PW'(1);
      end
      count <= count + CW'(alloc) - CW'(pop);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (alloc) begin
        q_reg[tail]  <= in_reg;
        q_data[tail] <= in_data;
      end
`ifdef REGWB_COALESCE_EN
      else if (coalesce) begin
        q_data[last] <= in_data;
      end
`endif
    end
  end

  // Oldest to youngest so later matches override; the output register is oldest of all.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    idx       = '0;
    if (RegWrite && (wr_reg == rd_reg1)) begin
      fwd_hit1  = 1'b1;
      fwd_data1 = wr_data;
    end
    if (RegWrite && (wr_reg == rd_reg2)) begin
      fwd_hit2  = 1'b1;
      fwd_data2 = wr_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count) begin
        if (q_reg[idx] == rd_reg1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = q_data[idx];
        end
        if (q_reg[idx] == rd_reg2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = q_data[idx];
        end
      end
    end
    if (DROP_R0 && (rd_reg1 == 5'd0)) begin
      fwd_hit1  = 1'b0;
      fwd_data1 = '0;
    end
    if (DROP_R0 && (rd_reg2 == 5'd0)) begin
      fwd_hit2  = 1'b0;
      fwd_data2 = '0;
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: directed scenarios plus random traffic against a queue model.
module tb_regfile_writeback_queue;

  localparam int DEPTH   = 4;
  localparam bit DROP_R0 = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_reg = '0;
  logic [31:0] in_data = '0;
  logic        wb_hold = 1'b0;
  logic        reg_write;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [4:0]  rd_reg1 = '0;
  logic [4:0]  rd_reg2 = '0;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;

  always #5 clk = ~clk;

  regfile_writeback_queue #(.DEPTH(DEPTH), .DROP_R0(DROP_R0)) dut (
    .Clk(clk), .Reset(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .wb_hold(wb_hold),
    .RegWrite(reg_write), .wr_reg(wr_reg), .wr_data(wr_data),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
    .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference: pending writes as a plain queue, plus the expected write-port register.
  logic [4:0]  mq_reg[$];
  logic [31:0] mq_data[$];
  logic        exp_rw;
  logic [4:0]  exp_wr_reg;
  logic [31:0] exp_wr_data;
  bit          model_known = 0;

  function automatic bit model_ready(input logic [4:0] r);
    bit rdy;
    rdy = (mq_reg.size() != DEPTH);
`ifdef REGWB_COALESCE_EN
    if (mq_reg.size() != 0 && mq_reg[$] == r) rdy = 1;
`endif
    return rdy;
  endfunction

  function automatic logic [32:0] model_fwd(input logic [4:0] a);
    logic        hit;
    logic [31:0] val;
    hit = 0;
    val = '0;
    if (exp_rw && exp_wr_reg == a) begin hit = 1; val = exp_wr_data; end
    foreach (mq_reg[i]) if (mq_reg[i] == a) begin hit = 1; val = mq_data[i]; end
    if (DROP_R0 && a == 5'd0) begin hit = 0; val = '0; end
    return {hit, val};
  endfunction

  task automatic step(input logic v, input logic [4:0] r, input logic [31:0] d, input logic h,
                      input logic rs, input logic [4:0] a1, input logic [4:0] a2);
    logic [32:0] f1, f2;
    bit acc, pop, coal, keep;
    int sz;
    @(negedge clk);
    in_valid = v; in_reg = r; in_data = d; wb_hold = h; rst = rs; rd_reg1 = a1; rd_reg2 = a2;
    #1;
    if (model_known) begin
      f1 = model_fwd(a1);
      f2 = model_fwd(a2);
      check_eq("in_ready", {31'd0, in_ready}, {31'd0, model_ready(r)});
      check_eq("fwd_hit1", {31'd0, fwd_hit1}, {31'd0, f1[32]});
      check_eq("fwd_data1", fwd_data1, f1[31:0]);
      check_eq("fwd_hit2", {31'd0, fwd_hit2}, {31'd0, f2[32]});
      check_eq("fwd_data2", fwd_data2, f2[31:0]);
    end
    acc  = v && model_ready(r);
    keep = acc && !(DROP_R0 && r == 5'd0);
    @(posedge clk);
    if (rs) begin
      mq_reg.delete(); mq_data.delete();
      exp_rw = 0; exp_wr_reg = '0; exp_wr_data = '0;
      model_known = 1;
    end else if (model_known) begin
      sz   = mq_reg.size();
      pop  = (sz != 0) && !h;
      coal = 0;
`ifdef REGWB_COALESCE_EN
      if (keep && sz != 0 && mq_reg[$] == r && !(pop && sz == 1)) coal = 1;
`endif
      if (pop) begin
        exp_rw = 1;
        exp_wr_reg = mq_reg.pop_front();
        exp_wr_data = mq_data.pop_front();
      end else begin
        exp_rw = 0;
      end
      if (keep) begin
        if (coal) mq_data[$] = d;
        else begin mq_reg.push_back(r); mq_data.push_back(d); end
      end
    end
    #1;
    if (model_known) begin
      check_eq("reg_write", {31'd0, reg_write}, {31'd0, exp_rw});
      check_eq("wr_reg", {27'd0, wr_reg}, {27'd0, exp_wr_reg});
      check_eq("wr_data", wr_data, exp_wr_data);
    end
  endtask

  task automatic idle(input logic h, input int n);
    for (int k = 0; k < n; k++) step(0, '0, '0, h, 0, 5'd3, 5'd4);
  endtask

  initial begin
    // Reset held two cycles
    step(0, '0, '0, 0, 1, '0, '0);
    step(0, '0, '0, 0, 1, '0, '0);
    idle(0, 1);
    check_eq("rst_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_regwrite", {31'd0, reg_write}, 32'd0);
    check_eq("rst_wr_data", wr_data, 32'd0);

    // Single write, minimum latency, one-cycle strobe
    step(1, 5'd15, 32'h1871, 0, 0, 5'd15, 5'd1);
    idle(0, 1);
    check_eq("lat_regwrite", {31'd0, reg_write}, 32'd1);
    check_eq("lat_wr_reg", {27'd0, wr_reg}, 32'd15);
    check_eq("lat_wr_data", wr_data, 32'h1871);
    idle(0, 1);
    check_eq("lat_strobe_len", {31'd0, reg_write}, 32'd0);

    // Fill under hold, back-pressure, then drain in order
    for (int k = 1; k <= 4; k++) step(1, 5'(k), 32'(k), 1, 0, 5'(k), 5'd2);
    check_eq("full_ready", {31'd0, in_ready}, 32'd0);
    step(1, 5'd5, 32'd5, 1, 0, 5'd1, 5'd4);
    step(1, 5'd5, 32'd5, 0, 0, 5'd1, 5'd4);
    step(1, 5'd5, 32'd5, 0, 0, 5'd5, 5'd2);
    idle(0, 6);

    // Forwarding picks the youngest value
    step(1, 5'd16, 32'h1249, 1, 0, 5'd16, 5'd15);
    step(1, 5'd16, 32'h2000, 1, 0, 5'd16, 5'd15);
    step(0, '0, '0, 1, 0, 5'd16, 5'd15);
    check_eq("fwd_young_hit", {31'd0, fwd_hit1}, 32'd1);
    check_eq("fwd_young_data", fwd_data1, 32'h2000);
    check_eq("fwd_miss_hit", {31'd0, fwd_hit2}, 32'd0);
    check_eq("fwd_miss_data", fwd_data2, 32'd0);
    idle(0, 4);

    // Register 0 writes are swallowed
    step(1, 5'd0, 32'hFFFF, 0, 0, 5'd0, 5'd0);
    step(0, '0, '0, 0, 0, 5'd0, 5'd0);
    check_eq("r0_regwrite", {31'd0, reg_write}, 32'd0);
    check_eq("r0_fwd_hit", {31'd0, fwd_hit1}, 32'd0);

    // Reset discards pending writes
    for (int k = 7; k <= 9; k++) step(1, 5'(k), 32'(k * 3), 1, 0, 5'd7, 5'd9);
    step(0, '0, '0, 1, 1, 5'd7, 5'd9);
    for (int k = 0; k < 3; k++) begin
      step(0, '0, '0, 0, 0, 5'd7, 5'd9);
      check_eq("rst_drop_regwrite", {31'd0, reg_write}, 32'd0);
    end

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 9) < 4, $urandom_range(0, 49) == 0,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(0, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
